udcount_mod: RTL and testbench

- Parametrised successor to the fixed 4-bit up/down counter used on the board test tops.
- Modulo-N up/down counter with:
  - generic width and modulus
  - synchronous clear and parallel load
  - wrap or saturate mode
  - cascadable carry/borrow
  - sticky overflow flag
- Sits between a debounced board input (push button / rotary switch) and the 7SEG/LED display path.
- Instances chain via carry_out -> enable to form multi-digit BCD or hex counters.

---
 rtl/udcount_mod_if.sv | 27 ++
 rtl/udcount_mod.sv | 96 +++++++++
 tb/tb_udcount_mod.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/udcount_mod_if.sv
// Control and status bundle for one udcount_mod stage.
// The master side drives direction, enable, clear, load and ovf_clr.
// The counter is the slave and returns q, carry_out, tc and ovf.
interface udcount_mod_if #(
    parameter int WIDTH = 4
);
    logic             ud;
    logic             enable;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             ovf_clr;
    logic [WIDTH-1:0] q;
    logic             carry_out;
    logic             tc;
    logic             ovf;

    modport master (
        output ud, enable, clear, load, d, ovf_clr,
        input  q, carry_out, tc, ovf
    );

    modport slave (
        input  ud, enable, clear, load, d, ovf_clr,
        output q, carry_out, tc, ovf
    );
endinterface

// File: rtl/udcount_mod.sv
// Modulo-MODULUS up/down counter with clear, clamped parallel load,
// wrap or saturate at the bounds, a combinational carry/borrow strobe
// for cascading digits, and a sticky overflow flag.
module udcount_mod #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter bit              SATURATE = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    udcount_mod_if.slave  bus
);
    localparam longint unsigned MOD_LIMIT = 64'd1 << WIDTH;

    // Reject widths and moduli the counter cannot represent.
    if ((WIDTH < 1) || (WIDTH > 32) || (MODULUS < 64'd2) || (MODULUS > MOD_LIMIT)) begin : g_bad_param
        $error("udcount_mod: illegal WIDTH/MODULUS combination");
    end

    // Upper bound of the count range, truncated to the counter width.
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             tc_s;
    logic             carry_s;

    // Terminal count and cascade strobe follow the current inputs with no latency.
    always_comb begin
        tc_s    = (bus.ud & (count_q == MAX_VAL)) | (~bus.ud & (count_q == ZERO_VAL));
        carry_s = bus.enable & tc_s & ~bus.clear & ~bus.load;
    end

    // Next count: clear, then load (clamped), then count step, else hold.
    always_comb begin
        count_d = count_q;
        if (bus.clear) begin
            count_d = ZERO_VAL;
        end else if (bus.load) begin
            // d above the top of range loads the top of range instead
            if (bus.d > MAX_VAL) begin
                count_d = MAX_VAL;
            end else begin
                count_d = bus.d;
            end
        end else if (bus.enable) begin
            if (bus.ud) begin
                if (count_q == MAX_VAL) begin
                    count_d = SATURATE ? count_q : ZERO_VAL;
                end else begin
                    count_d = count_q + ONE_VAL;
                end
            end else begin
                if (count_q == ZERO_VAL) begin
                    count_d = SATURATE ? count_q : MAX_VAL;
                end else begin
                    count_d = count_q - ONE_VAL;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Sticky overflow: a step taken at a bound sets it and beats ovf_clr.
    always_comb begin
        ovf_d = ovf_q;
        if (carry_s) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= ZERO_VAL;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.q         = count_q;
    assign bus.ovf       = ovf_q;
    assign bus.tc        = tc_s;
    assign bus.carry_out = carry_s;
endmodule

// File: tb/tb_udcount_mod.sv
// Directed bench for udcount_mod: a wrapping decade counter, a saturating
// decade counter and a two-digit cascade, all sharing one stimulus set.
module tb_udcount_mod;
    logic       clock;
    logic       reset;
    logic       ud;
    logic       enable;
    logic       clear;
    logic       load;
    logic [3:0] d;
    logic       ovf_clr;

    int checks;
    int errors;

    udcount_mod_if #(.WIDTH(4)) a_if ();
    udcount_mod_if #(.WIDTH(4)) s_if ();
    udcount_mod_if #(.WIDTH(4)) lo_if ();
    udcount_mod_if #(.WIDTH(4)) hi_if ();

    assign a_if.ud = ud;   assign a_if.enable = enable;   assign a_if.clear = clear;
    assign a_if.load = load; assign a_if.d = d;          assign a_if.ovf_clr = ovf_clr;
    assign s_if.ud = ud;   assign s_if.enable = enable;   assign s_if.clear = clear;
    assign s_if.load = load; assign s_if.d = d;          assign s_if.ovf_clr = ovf_clr;
    assign lo_if.ud = ud;  assign lo_if.enable = enable;  assign lo_if.clear = clear;
    assign lo_if.load = load; assign lo_if.d = d;        assign lo_if.ovf_clr = ovf_clr;
    assign hi_if.ud = ud;  assign hi_if.enable = lo_if.carry_out; assign hi_if.clear = clear;
    assign hi_if.load = load; assign hi_if.d = d;        assign hi_if.ovf_clr = ovf_clr;

    udcount_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a  (.clock(clock), .reset(reset), .bus(a_if.slave));
    udcount_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_s  (.clock(clock), .reset(reset), .bus(s_if.slave));
    udcount_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_lo (.clock(clock), .reset(reset), .bus(lo_if.slave));
    udcount_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_hi (.clock(clock), .reset(reset), .bus(hi_if.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({a_if.q, s_if.q, lo_if.q, hi_if.q} !== 16'h0000) begin
            errors++; $display("FAIL reset_q got %h want 0000", {a_if.q, s_if.q, lo_if.q, hi_if.q});
        end
        checks++;
        if ({a_if.ovf, s_if.ovf, lo_if.ovf, hi_if.ovf} !== 4'b0000) begin
            errors++; $display("FAIL reset_ovf got %b want 0000", {a_if.ovf, s_if.ovf, lo_if.ovf, hi_if.ovf});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_q;
        logic       exp_ovf;
        exp_q = 4'd0; exp_ovf = 1'b0;
        ud = 1'b1; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (a_if.carry_out !== (exp_q == 4'd9)) begin
                errors++; $display("FAIL up_carry step %0d got %b want %b", i, a_if.carry_out, (exp_q == 4'd9));
            end
            tick();
            if (exp_q == 4'd9) begin
                exp_q = 4'd0; exp_ovf = 1'b1;
            end else begin
                exp_q = exp_q + 4'd1;
            end
            checks++;
            if (a_if.q !== exp_q || a_if.ovf !== exp_ovf) begin
                errors++; $display("FAIL up_q step %0d got q=%0d ovf=%b want q=%0d ovf=%b", i, a_if.q, a_if.ovf, exp_q, exp_ovf);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_wrap_down();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        checks++;
        if (a_if.ovf !== 1'b0) begin
            errors++; $display("FAIL down_ovfclr got %b want 0", a_if.ovf);
        end
        ud = 1'b0; enable = 1'b1; #1;
        checks++;
        if (a_if.tc !== 1'b1 || a_if.carry_out !== 1'b1) begin
            errors++; $display("FAIL down_borrow got tc=%b co=%b want 1 1", a_if.tc, a_if.carry_out);
        end
        tick(); enable = 1'b0;
        checks++;
        if (a_if.q !== 4'd9 || a_if.ovf !== 1'b1) begin
            errors++; $display("FAIL down_wrap got q=%0d ovf=%b want q=9 ovf=1", a_if.q, a_if.ovf);
        end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        checks++;
        if (a_if.ovf !== 1'b0 || a_if.q !== 4'd9) begin
            errors++; $display("FAIL down_clr got q=%0d ovf=%b want q=9 ovf=0", a_if.q, a_if.ovf);
        end
        ud = 1'b1; #1;
        checks++;
        if (a_if.tc !== 1'b1 || a_if.carry_out !== 1'b0) begin
            errors++; $display("FAIL tc_no_enable got tc=%b co=%b want 1 0", a_if.tc, a_if.carry_out);
        end
    endtask

    task automatic test_saturate();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        load = 1'b1; d = 4'd9; tick(); load = 1'b0;
        ud = 1'b1; enable = 1'b1; ovf_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (s_if.carry_out !== 1'b1) begin
                errors++; $display("FAIL sat_carry step %0d got %b want 1", i, s_if.carry_out);
            end
            tick();
            ovf_clr = 1'b0;
            checks++;
            if (s_if.q !== 4'd9 || s_if.ovf !== 1'b1) begin
                errors++; $display("FAIL sat_hold step %0d got q=%0d ovf=%b want q=9 ovf=1", i, s_if.q, s_if.ovf);
            end
        end
        ud = 1'b0; tick(); enable = 1'b0;
        checks++;
        if (s_if.q !== 4'd8) begin
            errors++; $display("FAIL sat_down got %0d want 8", s_if.q);
        end
    endtask

    task automatic test_load();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        load = 1'b1; d = 4'hC; tick();
        checks++;
        if (a_if.q !== 4'd9) begin
            errors++; $display("FAIL load_clamp got %0d want 9", a_if.q);
        end
        clear = 1'b1; d = 4'd3; enable = 1'b1; ud = 1'b1; #1;
        checks++;
        if (a_if.tc !== 1'b1 || a_if.carry_out !== 1'b0) begin
            errors++; $display("FAIL load_carry_mask got tc=%b co=%b want 1 0", a_if.tc, a_if.carry_out);
        end
        tick(); clear = 1'b0;
        checks++;
        if (a_if.q !== 4'd0) begin
            errors++; $display("FAIL clear_over_load got %0d want 0", a_if.q);
        end
        d = 4'd5; tick(); load = 1'b0; enable = 1'b0;
        checks++;
        if (a_if.q !== 4'd5 || a_if.ovf !== 1'b0) begin
            errors++; $display("FAIL load_over_count got q=%0d ovf=%b want q=5 ovf=0", a_if.q, a_if.ovf);
        end
    endtask

    task automatic test_cascade();
        int exp_v;
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if ({hi_if.q, lo_if.q} !== 8'h00) begin
            errors++; $display("FAIL casc_clear got %h want 00", {hi_if.q, lo_if.q});
        end
        ud = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            #1;
            checks++;
            if (lo_if.carry_out !== (lo_if.q == 4'd9 ? 1'b1 : 1'b0) || lo_if.q !== 4'((i - 1) % 10)) begin
                errors++; $display("FAIL casc_carry step %0d got lo=%0d co=%b", i, lo_if.q, lo_if.carry_out);
            end
            tick();
            exp_v = i % 100;
            checks++;
            if (hi_if.q !== 4'(exp_v / 10) || lo_if.q !== 4'(exp_v % 10)) begin
                errors++; $display("FAIL casc_count step %0d got %0d%0d want %0d", i, hi_if.q, lo_if.q, exp_v);
            end
        end
        enable = 1'b0;
        checks++;
        if (hi_if.ovf !== 1'b1) begin
            errors++; $display("FAIL casc_hi_ovf got %b want 1", hi_if.ovf);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; d = 4'd7; tick(); load = 1'b0;
        checks++;
        if (a_if.q !== 4'd7 || a_if.ovf !== 1'b1) begin
            errors++; $display("FAIL pre_reset got q=%0d ovf=%b want q=7 ovf=1", a_if.q, a_if.ovf);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (a_if.q !== 4'd0 || a_if.ovf !== 1'b0) begin
            errors++; $display("FAIL async_reset got q=%0d ovf=%b want q=0 ovf=0", a_if.q, a_if.ovf);
        end
        #1 reset = 1'b0;
        ud = 1'b1; enable = 1'b1; tick(); enable = 1'b0;
        checks++;
        if (a_if.q !== 4'd1) begin
            errors++; $display("FAIL post_reset_count got %0d want 1", a_if.q);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; ud = 1'b1; enable = 1'b0; clear = 1'b0;
        load = 1'b0; d = 4'd0; ovf_clr = 1'b0;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_cascade();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
